pix_scan_ctrl: RTL and testbench

//  Scan sequencer for the LF_SFF pixel readout. Steps row/col through a frame and, per pixel:

---
 rtl/pix_scan_ctrl_pkg.sv | 29 ++
 rtl/pix_scan_ctrl_scan_addr_cnt.sv | 57 +++++
 rtl/pix_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pix_scan_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pix_scan_ctrl_pkg.sv
// Shared definitions for the LF_SFF pixel scan sequencer.
// Holds the FSM state encoding, the default widths and a small helper
// used to decide whether a finished frame ends the scan.
package pix_scan_ctrl_pkg;

  localparam int N_CH_DEF      = 4;
  localparam int ROW_BITS_DEF  = 6;
  localparam int COL_BITS_DEF  = 6;
  localparam int WAIT_BITS_DEF = 16;
  localparam int TO_BITS_DEF   = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_CNT  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SEQ      = 3'd3,
    ST_SYNC     = 3'd4,
    ST_NEXT     = 3'd5,
    ST_THROTTLE = 3'd6,
    ST_FINISH   = 3'd7
  } scan_state_t;

  // A repeat count of zero means "run until aborted", so it never ends the scan.
  function automatic logic last_frame(input logic [15:0] frames_done,
                                      input logic [7:0]  repeat_n);
    return (repeat_n != 8'd0) && (frames_done == {8'd0, repeat_n});
  endfunction

endpackage

// File: rtl/pix_scan_ctrl_scan_addr_cnt.sv
// scan_addr_cnt: row/column address counter for the pixel scan.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clr               force row and column to zero
//   i_step              advance one pixel (column first, then row, wrapping)
//   i_cfg_rows/cols     last row / last column index of the frame
//   o_row, o_col        current pixel address
//   o_last_col/row      current address sits on the last column / row
module scan_addr_cnt #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_step,
  input  logic [ROW_BITS-1:0] i_cfg_rows,
  input  logic [COL_BITS-1:0] i_cfg_cols,
  output logic [ROW_BITS-1:0] o_row,
  output logic [COL_BITS-1:0] o_col,
  output logic                o_last_col,
  output logic                o_last_row
);

  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic                w_last_col;
  logic                w_last_row;

  // >= rather than == so an out-of-range address can never run away.
  assign w_last_col = (r_col >= i_cfg_cols);
  assign w_last_row = (r_row >= i_cfg_rows);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_step) begin
      if (!w_last_col) begin
        r_col <= r_col + COL_BITS'(1);
      end else begin
        r_col <= '0;
        if (!w_last_row) r_row <= r_row + ROW_BITS'(1);
        else             r_row <= '0;
      end
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_last_col = w_last_col;
  assign o_last_row = w_last_row;

endmodule

// File: rtl/pix_scan_ctrl.sv
// pix_scan_ctrl: scan sequencer for the LF_SFF pixel readout.
// Walks row/col through a frame; per pixel it settles, fires seq_gen, waits
// for its done and then pulses ADC_SYNC. Back-pressure from the output FIFO
// holds the scan before seq_gen is started.
// Ports (all on BUS_CLK, BUS_RST asynchronous active-high):
//   START/ABORT              scan control pulses
//   CONF_*                   configuration, shadowed when the scan starts
//   SEQ_DONE, FIFO_NEAR_FULL seq_gen handshake and downstream back-pressure
//   SEQ_START, ADC_SYNC,
//   RESET_ROW/COL_CNT        registered one-cycle strobes
//   ROW, COL, FRAME_CNT      scan position and completed frame count
//   BUSY, DONE, ERROR        status (DONE/ERROR sticky until next START)
module pix_scan_ctrl
  import pix_scan_ctrl_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int ROW_BITS  = ROW_BITS_DEF,
  parameter int COL_BITS  = COL_BITS_DEF,
  parameter int WAIT_BITS = WAIT_BITS_DEF,
  parameter int TO_BITS   = TO_BITS_DEF
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [ROW_BITS-1:0]  CONF_ROWS,
  input  logic [COL_BITS-1:0]  CONF_COLS,
  input  logic [7:0]           CONF_REPEAT,
  input  logic [WAIT_BITS-1:0] CONF_WAIT,
  input  logic [N_CH-1:0]      CONF_CH_EN,
  input  logic                 SEQ_DONE,
  input  logic                 FIFO_NEAR_FULL,
  output logic                 SEQ_START,
  output logic [N_CH-1:0]      ADC_SYNC,
  output logic                 RESET_ROW_CNT,
  output logic                 RESET_COL_CNT,
  output logic [ROW_BITS-1:0]  ROW,
  output logic [COL_BITS-1:0]  COL,
  output logic [15:0]          FRAME_CNT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR
);

  // The timeout fires on the edge that takes the counter to all-ones.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  scan_state_t r_state, w_next;

  logic [ROW_BITS-1:0]  r_rows;
  logic [COL_BITS-1:0]  r_cols;
  logic [7:0]           r_repeat;
  logic [WAIT_BITS-1:0] r_wait;
  logic [N_CH-1:0]      r_ch_en;

  logic [WAIT_BITS-1:0] r_wait_cnt;
  logic [TO_BITS-1:0]   r_to_cnt;
  logic [15:0]          r_frame_cnt;

  logic                 r_seq_start;
  logic [N_CH-1:0]      r_adc_sync;
  logic                 r_rst_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic                 w_load_cfg;
  logic                 w_step;
  logic                 w_frame_inc;
  logic                 w_set_done;
  logic                 w_set_error;
  logic                 w_enter_settle;
  logic                 w_enter_seq;

  logic [ROW_BITS-1:0]  w_row;
  logic [COL_BITS-1:0]  w_col;
  logic                 w_last_col;
  logic                 w_last_row;

  scan_addr_cnt #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_addr (
    .i_clk      (BUS_CLK),
    .i_rst      (BUS_RST),
    .i_clr      (w_load_cfg),
    .i_step     (w_step),
    .i_cfg_rows (r_rows),
    .i_cfg_cols (r_cols),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_cfg  = 1'b0;
    w_step      = 1'b0;
    w_frame_inc = 1'b0;
    w_set_done  = 1'b0;
    w_set_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_load_cfg = 1'b1;
          w_next     = ST_RST_CNT;
        end
      end
      ST_RST_CNT:  w_next = ST_SETTLE;
      ST_SETTLE: begin
        if (r_wait_cnt == '0) w_next = FIFO_NEAR_FULL ? ST_THROTTLE : ST_SEQ;
      end
      ST_THROTTLE: begin
        if (!FIFO_NEAR_FULL) w_next = ST_SEQ;
      end
      ST_SEQ: begin
        if (SEQ_DONE) begin
          w_next = ST_SYNC;
        end else if (r_to_cnt == TO_LAST) begin
          w_set_error = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_SYNC:     w_next = ST_NEXT;
      ST_NEXT: begin
        w_step = 1'b1;
        if (w_last_col && w_last_row) begin
          w_frame_inc = 1'b1;
          w_next = last_frame(r_frame_cnt + 16'd1, r_repeat) ? ST_FINISH : ST_RST_CNT;
        end else begin
          w_next = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        w_set_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default:     w_next = ST_IDLE;
    endcase
    // Abort wins over everything else and suppresses all side effects.
    if (ABORT && (r_state != ST_IDLE)) begin
      w_next      = ST_IDLE;
      w_step      = 1'b0;
      w_frame_inc = 1'b0;
      w_set_done  = 1'b0;
      w_set_error = 1'b0;
    end
    w_enter_settle = (w_next == ST_SETTLE) && (r_state != ST_SETTLE);
    w_enter_seq    = (w_next == ST_SEQ)    && (r_state != ST_SEQ);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_rows      <= '0;
      r_cols      <= '0;
      r_repeat    <= '0;
      r_wait      <= '0;
      r_ch_en     <= '0;
      r_wait_cnt  <= '0;
      r_to_cnt    <= '0;
      r_frame_cnt <= '0;
      r_seq_start <= 1'b0;
      r_adc_sync  <= '0;
      r_rst_cnt   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_load_cfg) begin
        r_rows   <= CONF_ROWS;
        r_cols   <= CONF_COLS;
        r_repeat <= CONF_REPEAT;
        r_wait   <= CONF_WAIT;
        r_ch_en  <= CONF_CH_EN;
      end

      if (w_enter_settle)                               r_wait_cnt <= r_wait;
      else if ((r_state == ST_SETTLE) && (r_wait_cnt != '0)) r_wait_cnt <= r_wait_cnt - WAIT_BITS'(1);

      if (w_enter_seq)               r_to_cnt <= '0;
      else if (r_state == ST_SEQ)    r_to_cnt <= r_to_cnt + TO_BITS'(1);

      if (w_load_cfg)       r_frame_cnt <= '0;
      else if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_load_cfg)      r_done <= 1'b0;
      else if (w_set_done) r_done <= 1'b1;

      if (w_load_cfg)       r_error <= 1'b0;
      else if (w_set_error) r_error <= 1'b1;

      // Strobes are registered from the next state so each is a clean
      // single-cycle pulse aligned with the state it belongs to.
      r_seq_start <= w_enter_seq;
      r_adc_sync  <= (w_next == ST_SYNC) ? r_ch_en : '0;
      r_rst_cnt   <= (w_next == ST_RST_CNT);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  assign SEQ_START     = r_seq_start;
  assign ADC_SYNC      = r_adc_sync;
  assign RESET_ROW_CNT = r_rst_cnt;
  assign RESET_COL_CNT = r_rst_cnt;
  assign ROW           = w_row;
  assign COL           = w_col;
  assign FRAME_CNT     = r_frame_cnt;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign ERROR         = r_error;

endmodule

// File: tb/tb_pix_scan_ctrl.sv
module tb_pix_scan_ctrl;

  localparam int N_CH = 4;
  localparam int RB   = 6;
  localparam int CB   = 6;
  localparam int WB   = 16;
  localparam int TB   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RB-1:0] conf_rows = '0;
  logic [CB-1:0] conf_cols = '0;
  logic [7:0]    conf_repeat = '0;
  logic [WB-1:0] conf_wait = '0;
  logic [N_CH-1:0] conf_ch_en = '0;
  logic          fifo_nf = 1'b0;
  logic          auto_done = 1'b0;
  logic          force_done = 1'b0;
  logic          auto_en = 1'b0;
  logic          seq_done;

  logic          seq_start;
  logic [N_CH-1:0] adc_sync;
  logic          rst_row, rst_col;
  logic [RB-1:0] row;
  logic [CB-1:0] col;
  logic [15:0]   frame_cnt;
  logic          busy, done, error;

  assign seq_done = auto_done | force_done;

  pix_scan_ctrl #(
    .N_CH(N_CH), .ROW_BITS(RB), .COL_BITS(CB), .WAIT_BITS(WB), .TO_BITS(TB)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .START(start), .ABORT(abort),
    .CONF_ROWS(conf_rows), .CONF_COLS(conf_cols), .CONF_REPEAT(conf_repeat),
    .CONF_WAIT(conf_wait), .CONF_CH_EN(conf_ch_en), .SEQ_DONE(seq_done),
    .FIFO_NEAR_FULL(fifo_nf), .SEQ_START(seq_start), .ADC_SYNC(adc_sync),
    .RESET_ROW_CNT(rst_row), .RESET_COL_CNT(rst_col), .ROW(row), .COL(col),
    .FRAME_CNT(frame_cnt), .BUSY(busy), .DONE(done), .ERROR(error)
  );

  always #5 clk = ~clk;

  // Pulse monitor and seq_gen model, sampling mid-cycle.
  int n_seq = 0, n_adc = 0, n_rst = 0, n_badmask = 0, n_excl = 0;
  int done_cd = -1;
  logic [N_CH-1:0] exp_mask = '0;
  logic [RB+CB-1:0] adc_log [64];

  always @(negedge clk) begin
    int s;
    s = int'(seq_start) + int'(|adc_sync) + int'(rst_row);
    if (s > 1) n_excl++;
    if (rst_row != rst_col) n_excl++;
    if (seq_start) n_seq++;
    if (rst_row) n_rst++;
    if (|adc_sync) begin
      adc_log[n_adc % 64] = {row, col};
      if (adc_sync != exp_mask) n_badmask++;
      n_adc++;
    end
    auto_done = (done_cd == 0);
    if (done_cd >= 0) done_cd--;
    if (seq_start && auto_en) done_cd = 2;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_test1(input string tag);
    int b_seq, b_adc, b_rst, b_bad, b_excl, k;
    conf_rows = 6'd1; conf_cols = 6'd2; conf_repeat = 8'd1; conf_wait = '0;
    conf_ch_en = 4'b1011; exp_mask = 4'b1011; auto_en = 1'b1; fifo_nf = 1'b0;
    b_seq = n_seq; b_adc = n_adc; b_rst = n_rst; b_bad = n_badmask; b_excl = n_excl;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_rst_latency"}, {62'd0, rst_row, busy}, 64'd3);
    k = 0;
    while (busy && k < 200) begin tick(); k++; end
    check({tag, "_finish_in_time"}, 64'(k < 200), 64'd1);
    check({tag, "_seq_starts"}, 64'(n_seq - b_seq), 64'd6);
    check({tag, "_adc_syncs"}, 64'(n_adc - b_adc), 64'd6);
    check({tag, "_rst_pulses"}, 64'(n_rst - b_rst), 64'd1);
    check({tag, "_bad_mask"}, 64'(n_badmask - b_bad), 64'd0);
    check({tag, "_exclusive"}, 64'(n_excl - b_excl), 64'd0);
    check({tag, "_status"}, {44'd0, frame_cnt, busy, done, error, 1'b0}, {44'd0, 16'd1, 4'b0100});
    for (int i = 0; i < 6; i++)
      check({tag, "_order"}, 64'(adc_log[(b_adc + i) % 64]), 64'({6'(i / 3), 6'(i % 3)}));
  endtask

  initial begin
    int k, b_seq, b_adc, b_rst;
    #2;
    check("reset_outputs",
          64'({seq_start, adc_sync, rst_row, rst_col, row, col, frame_cnt, busy, done, error}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: basic two-row frame
    run_test1("t1");

    // 2: back-pressure spanning the end of settle
    conf_rows = '0; conf_cols = '0; conf_repeat = 8'd1; conf_wait = 16'd10;
    auto_en = 1'b1;
    b_seq = n_seq;
    fifo_nf = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    check("t2_no_seq_while_full", 64'(n_seq - b_seq), 64'd0);
    check("t2_busy_while_full", 64'(busy), 64'd1);
    fifo_nf = 1'b0;
    tick();
    check("t2_seq_after_drop", 64'(seq_start), 64'd1);
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check("t2_done", {62'd0, busy, done}, 64'd1);

    // 3: seq_gen never answers
    auto_en = 1'b0;
    b_adc = n_adc;
    conf_wait = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!seq_start && k < 50) begin tick(); k++; end
    check("t3_seq_start_seen", 64'(seq_start), 64'd1);
    k = 0;
    while (!error && k < 100) begin tick(); k++; end
    check("t3_timeout_cycles", 64'(k), 64'd63);
    check("t3_status", {61'd0, busy, done, error}, 64'd1);
    check("t3_no_adc", 64'(n_adc - b_adc), 64'd0);

    // 4: abort and done together in SEQ
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!seq_start && k < 50) begin tick(); k++; end
    b_adc = n_adc;
    abort = 1'b1; force_done = 1'b1;
    tick();
    abort = 1'b0; force_done = 1'b0;
    check("t4_idle_next", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t4_no_adc", 64'(n_adc - b_adc), 64'd0);
    check("t4_flags", {62'd0, done, error}, 64'd0);
    run_test1("t4_rerun");

    // 5: continuous scan, config change ignored, abort after 3 frames
    conf_rows = '0; conf_cols = '0; conf_repeat = 8'd0; conf_wait = '0;
    conf_ch_en = 4'b0110; exp_mask = 4'b0110; auto_en = 1'b1;
    b_adc = n_adc; b_rst = n_rst; k = n_badmask;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    conf_ch_en = 4'b1111; conf_repeat = 8'd1;
    b_seq = 0;
    while (frame_cnt != 16'd3 && b_seq < 200) begin tick(); b_seq++; end
    check("t5_reached_3", 64'(frame_cnt), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_aborted", {62'd0, busy, done}, 64'd0);
    check("t5_frames", 64'(frame_cnt), 64'd3);
    check("t5_adc_count", 64'(n_adc - b_adc), 64'd3);
    check("t5_mask_kept", 64'(n_badmask - k), 64'd0);
    check("t5_rst_per_frame", 64'(n_rst - b_rst), 64'd4);

    // 6: asynchronous reset mid-scan
    conf_rows = 6'd1; conf_cols = 6'd2; conf_repeat = 8'd1; conf_ch_en = 4'b1011;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("t6_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_clear",
          64'({seq_start, adc_sync, rst_row, rst_col, row, col, frame_cnt, busy, done, error}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    run_test1("t6_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
